// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the multi-cycle control path: opcode constants,
// FSM state encoding, datapath select encodings and opcode classification.
package rv32i_pkg;

   // Base opcodes (instruction[6:0])
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // Controller state encoding
   typedef logic [2:0] state_t;
   localparam state_t S_FETCH  = 3'd0;
   localparam state_t S_DECODE = 3'd1;
   localparam state_t S_EXEC   = 3'd2;
   localparam state_t S_MEM    = 3'd3;
   localparam state_t S_WB     = 3'd4;
   localparam state_t S_TRAP   = 3'd5;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0,
      PC_IMM   = 2'd1,
      PC_JALR  = 2'd2
   } pc_src_e;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2
   } wb_sel_e;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'd0,
      ALU_FUNCT  = 2'd1,
      ALU_BRANCH = 2'd2
   } alu_op_e;

   // Instruction class as seen by the sequencer
   typedef enum logic [3:0] {
      CL_ILLEGAL,
      CL_ALU_R,
      CL_ALU_I,
      CL_LOAD,
      CL_STORE,
      CL_BRANCH,
      CL_JAL,
      CL_JALR,
      CL_LUI,
      CL_AUIPC,
      CL_FENCE,
      CL_SYSTEM,
      CL_ENV
   } op_class_e;

   // ECALL/EBREAK live in the PRIV group (funct3 = 0); CSR ops reuse
   // funct12 as a CSR address, so they are not mistaken for a trap.
   function automatic op_class_e classify(input logic [6:0]  opcode,
                                          input logic [2:0]  funct3,
                                          input logic [11:0] funct12);
      op_class_e c;
      case (opcode)
         OPC_OP:       c = CL_ALU_R;
         OPC_OP_IMM:   c = CL_ALU_I;
         OPC_LOAD:     c = CL_LOAD;
         OPC_STORE:    c = CL_STORE;
         OPC_BRANCH:   c = CL_BRANCH;
         OPC_JAL:      c = CL_JAL;
         OPC_JALR:     c = CL_JALR;
         OPC_LUI:      c = CL_LUI;
         OPC_AUIPC:    c = CL_AUIPC;
         OPC_MISC_MEM: c = CL_FENCE;
         OPC_SYSTEM:   c = (funct3 == 3'b000 && funct12[11:1] == 11'd0) ? CL_ENV : CL_SYSTEM;
         default:      c = CL_ILLEGAL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB one
// instruction at a time, drives the datapath strobes and selects, and counts
// retired instructions. All strobes are combinational from the state and are
// forced low while rst_n is asserted so requests drop without waiting for a clock.
module multicycle_controller
   import rv32i_pkg::*;
#(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic [11:0]          funct12,
   input  logic                 branch_taken,
   output logic                 imem_req,
   input  logic                 imem_ready,
   output logic                 dmem_req,
   output logic                 dmem_we,
   input  logic                 dmem_ready,
   output logic                 ir_wr_en,
   output logic                 pc_wr_en,
   output logic [1:0]           pc_src,
   output logic                 regfile_wr_en,
   output logic [1:0]           wb_sel,
   output logic [1:0]           alu_op,
   output logic                 alu_src_b_imm,
   output logic                 trap,
   output logic [INSTRET_W-1:0] instret
);

   state_t    state_q;
   state_t    state_d;
   op_class_e cls;

   // Classify the instruction currently held in IR
   always_comb begin
      cls = classify(opcode, funct3, funct12);
   end

   // Next-state and Mealy output decode
   always_comb begin
      state_d       = state_q;
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      ir_wr_en      = 1'b0;
      pc_wr_en      = 1'b0;
      pc_src        = PC_PLUS4;
      regfile_wr_en = 1'b0;
      wb_sel        = WB_ALU;
      alu_op        = ALU_ADD;
      alu_src_b_imm = 1'b0;
      trap          = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_wr_en = 1'b1;
                  state_d  = S_DECODE;
               end
            end
            S_DECODE: begin
               case (cls)
                  CL_ILLEGAL, CL_ENV: state_d = S_TRAP;
                  CL_FENCE, CL_SYSTEM: begin
                     pc_wr_en = 1'b1;
                     state_d  = S_FETCH;
                  end
                  default: state_d = S_EXEC;
               endcase
            end
            S_EXEC: begin
               alu_src_b_imm = cls inside {CL_ALU_I, CL_LOAD, CL_STORE, CL_LUI, CL_AUIPC, CL_JALR};
               case (cls)
                  CL_ALU_R, CL_ALU_I: begin
                     alu_op  = ALU_FUNCT;
                     state_d = S_WB;
                  end
                  CL_LOAD, CL_STORE: state_d = S_MEM;
                  CL_BRANCH: begin
                     alu_op   = ALU_BRANCH;
                     pc_wr_en = 1'b1;
                     pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
                     state_d  = S_FETCH;
                  end
                  default: state_d = S_WB;
               endcase
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (cls == CL_STORE);
               if (dmem_ready) begin
                  if (cls == CL_STORE) begin
                     pc_wr_en = 1'b1;
                     state_d  = S_FETCH;
                  end else begin
                     state_d  = S_WB;
                  end
               end
            end
            S_WB: begin
               regfile_wr_en = 1'b1;
               pc_wr_en      = 1'b1;
               case (cls)
                  CL_LOAD:          wb_sel = WB_LOAD;
                  CL_JAL, CL_JALR:  wb_sel = WB_PC4;
                  default:          wb_sel = WB_ALU;
               endcase
               case (cls)
                  CL_JAL:  pc_src = PC_IMM;
                  CL_JALR: pc_src = PC_JALR;
                  default: pc_src = PC_PLUS4;
               endcase
               state_d = S_FETCH;
            end
            S_TRAP: trap = 1'b1;
            default: state_d = S_FETCH;
         endcase
      end
   end

   // State register and retired-instruction counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         instret <= '0;
      end else begin
         state_q <= state_d;
         if (pc_wr_en)
            instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is expanded
// into a list of expected per-cycle control vectors from the instruction's
// class and the chosen memory wait counts; a narrow counter exercises wrap.
module tb_multicycle_controller;

   localparam int IW = 4;

   // Bit positions in the packed control vector
   localparam int B_IMEM = 13;
   localparam int B_IR   = 12;
   localparam int B_DMEM = 11;
   localparam int B_WE   = 10;
   localparam int B_PCW  = 9;
   localparam int B_PCS  = 7;
   localparam int B_RF   = 6;
   localparam int B_WB   = 4;
   localparam int B_ALU  = 2;
   localparam int B_IMM  = 1;
   localparam int B_TRAP = 0;
   localparam logic [13:0] SM = 14'b11101001000001;

   logic          clk;
   logic          rst_n;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic [11:0]   funct12;
   logic          branch_taken;
   logic          imem_req;
   logic          imem_ready;
   logic          dmem_req;
   logic          dmem_we;
   logic          dmem_ready;
   logic          ir_wr_en;
   logic          pc_wr_en;
   logic [1:0]    pc_src;
   logic          regfile_wr_en;
   logic [1:0]    wb_sel;
   logic [1:0]    alu_op;
   logic          alu_src_b_imm;
   logic          trap;
   logic [IW-1:0] instret;

   multicycle_controller #(.INSTRET_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct12(funct12),
      .branch_taken(branch_taken), .imem_req(imem_req), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .ir_wr_en(ir_wr_en), .pc_wr_en(pc_wr_en), .pc_src(pc_src),
      .regfile_wr_en(regfile_wr_en), .wb_sel(wb_sel), .alu_op(alu_op),
      .alu_src_b_imm(alu_src_b_imm), .trap(trap), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [13:0] v;
      logic [13:0] m;
      bit          ir;
      bit          dr;
      bit          bt;
      bit          dec;
   } cyc_t;

   cyc_t        q[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          exp_ret    = 0;
   int          cyc        = 0;
   logic [31:0] cur_w;

   function automatic logic [13:0] obs_v();
      return {imem_req, ir_wr_en, dmem_req, dmem_we, pc_wr_en, pc_src, regfile_wr_en,
              wb_sel, alu_op, alu_src_b_imm, trap};
   endfunction

   function automatic logic [13:0] fld(input int pos, input int w, input int val);
      logic [13:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[pos+i] = val[i];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input logic [13:0] v, input logic [13:0] m, input bit ir,
                       input bit dr, input bit bt, input bit dec);
      cyc_t c;
      c.v = v; c.m = m; c.ir = ir; c.dr = dr; c.bt = bt; c.dec = dec;
      q.push_back(c);
   endtask

   // Expand one instruction into its expected cycle sequence
   task automatic build(input logic [31:0] w, input int iw, input int dw, input bit bt,
                        output bit traps);
      logic [6:0]  op;
      logic [13:0] v, m;
      bit r, i, ld, st, br, jal, jalr, lui, aui, fen, sys, env, legal;
      op = w[6:0];
      r = (op == 7'h33); i = (op == 7'h13); ld = (op == 7'h03); st = (op == 7'h23);
      br = (op == 7'h63); jal = (op == 7'h6f); jalr = (op == 7'h67); lui = (op == 7'h37);
      aui = (op == 7'h17); fen = (op == 7'h0f); sys = (op == 7'h73);
      legal = r | i | ld | st | br | jal | jalr | lui | aui | fen | sys;
      env = sys && (w[14:12] == 3'd0) && (w[31:20] <= 12'd1);
      traps = 1'b0;
      for (int k = 0; k <= iw; k++)
         push(fld(B_IMEM, 1, 1) | ((k == iw) ? fld(B_IR, 1, 1) : 14'd0), SM,
              (k == iw), 1'($urandom), 1'($urandom), 1'b0);
      if (!legal || env) begin
         push(14'd0, SM, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         traps = 1'b1;
         return;
      end
      if (fen || sys) begin
         push(fld(B_PCW, 1, 1), SM | fld(B_PCS, 2, 3), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         return;
      end
      push(14'd0, SM, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      v = fld(B_ALU, 2, (r || i) ? 1 : (br ? 2 : 0)) | fld(B_IMM, 1, int'(i | ld | st | lui | aui | jalr));
      m = SM | fld(B_ALU, 2, 3) | fld(B_IMM, 1, 1);
      if (br) begin
         v |= fld(B_PCW, 1, 1) | fld(B_PCS, 2, bt ? 1 : 0);
         m |= fld(B_PCS, 2, 3);
      end
      push(v, m, 1'($urandom), 1'($urandom), br ? bt : 1'($urandom), 1'b1);
      if (br) return;
      if (ld || st) begin
         for (int k = 0; k <= dw; k++) begin
            v = fld(B_DMEM, 1, 1) | fld(B_WE, 1, int'(st));
            m = SM | fld(B_WE, 1, 1);
            if (k == dw && st) begin
               v |= fld(B_PCW, 1, 1);
               m |= fld(B_PCS, 2, 3);
            end
            push(v, m, 1'($urandom), (k == dw), 1'($urandom), 1'b1);
         end
         if (st) return;
      end
      v = fld(B_RF, 1, 1) | fld(B_PCW, 1, 1) | fld(B_WB, 2, ld ? 1 : ((jal || jalr) ? 2 : 0))
        | fld(B_PCS, 2, jal ? 1 : (jalr ? 2 : 0));
      push(v, SM | fld(B_WB, 2, 3) | fld(B_PCS, 2, 3), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
   endtask

   // Play n queued cycles (all when n < 0); entered and left on a negedge
   task automatic run_q(input int n);
      cyc_t c;
      int   done = 0;
      while (q.size() > 0 && (n < 0 || done < n)) begin
         c = q.pop_front();
         imem_ready   = c.ir;
         dmem_ready   = c.dr;
         branch_taken = c.bt;
         if (c.dec) begin
            opcode = cur_w[6:0]; funct3 = cur_w[14:12]; funct12 = cur_w[31:20];
         end else begin
            opcode = 7'($urandom); funct3 = 3'($urandom); funct12 = 12'($urandom);
         end
         #1;
         check("ctrl", {18'd0, obs_v() & c.m}, {18'd0, c.v & c.m});
         check("instret", {{(32-IW){1'b0}}, instret}, 32'(exp_ret % (1 << IW)));
         if (c.v[B_PCW]) exp_ret++;
         cyc++;
         @(negedge clk);
         done++;
      end
   endtask

   task automatic do_instr(input logic [31:0] w, input int iw, input int dw, input bit bt);
      bit t;
      cur_w = w;
      build(w, iw, dw, bt, t);
      if (t)
         for (int k = 0; k < 20; k++)
            push(fld(B_TRAP, 1, 1), SM, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      run_q(-1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_outs", {18'd0, obs_v()}, 32'd0);
      check("rst_instret", {{(32-IW){1'b0}}, instret}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_ret = 0;
   endtask

   function automatic logic [31:0] rand_legal();
      logic [6:0]  ops [11];
      logic [31:0] w;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73};
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 10)];
      if (w[6:0] == 7'h73 && w[31:20] <= 12'd1) w[31:20] = 12'h105;
      return w;
   endfunction

   initial begin
      rst_n = 1'b0; opcode = '0; funct3 = '0; funct12 = '0;
      branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      @(negedge clk);
      do_reset();

      do_instr(32'h002081B3, 0, 0, 1'b0);   // ADD
      do_instr(32'h0000A103, 0, 3, 1'b0);   // LW, 3 wait states
      do_instr(32'h00208463, 0, 0, 1'b1);   // BEQ taken
      do_instr(32'h00208463, 1, 0, 1'b0);   // BEQ not taken
      do_instr(32'h000080E7, 0, 0, 1'b0);   // JALR
      do_instr(32'h0020A023, 0, 0, 1'b0);   // SW
      do_instr(32'h0080006F, 2, 0, 1'b0);   // JAL
      do_instr(32'h123450B7, 0, 0, 1'b0);   // LUI
      do_instr(32'h00001097, 0, 0, 1'b0);   // AUIPC
      do_instr(32'h0FF0000F, 0, 0, 1'b0);   // FENCE
      do_instr(32'h30002173, 0, 0, 1'b0);   // CSRRS (non-trapping SYSTEM)
      do_instr(32'h00500093, 0, 0, 1'b0);   // ADDI
      for (int k = 0; k < 40; k++)
         do_instr(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));

      do_instr(32'h0000007F, 0, 0, 1'b0);   // illegal opcode -> TRAP
      do_reset();
      do_instr(32'h00000073, 0, 0, 1'b0);   // ECALL -> TRAP
      do_reset();
      do_instr(32'h00100073, 1, 0, 1'b0);   // EBREAK -> TRAP
      do_reset();

      // Reset asserted while a load is waiting in MEM
      do_instr(32'h002081B3, 0, 0, 1'b0);
      begin
         bit t;
         cur_w = 32'h0000A103;
         build(cur_w, 0, 5, 1'b0, t);
         run_q(4);                          // FETCH, DECODE, EXEC, first MEM
         dmem_ready = 1'b0;
         #1;
         check("mem_req_before_rst", {31'd0, dmem_req}, 32'd1);
         rst_n = 1'b0;
         #1;
         check("mem_req_rst_drop", {18'd0, obs_v()}, 32'd0);
         check("mem_rst_instret", {{(32-IW){1'b0}}, instret}, 32'd0);
         q.delete();
         @(negedge clk);
         rst_n = 1'b1;
         imem_ready = 1'b0;
         exp_ret = 0;
         #1;
         check("fetch_after_rst", {18'd0, obs_v()}, {18'd0, fld(B_IMEM, 1, 1)});
         @(negedge clk);
         do_instr(32'h002081B3, 0, 0, 1'b0);   // recovery from the pending fetch
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle RV32I control FSM; sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Drives the register file write enable, IR load, PC update, datapath mux selects and the instruction/data memory request handshakes.
- Sits beside the register file and ALU in the CPU core.
- Also counts retired instructions.

Parameters:
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  7  instruction[6:0] from IR, valid from DECODE onward
- funct3  in  3  instruction[14:12] from IR
- funct12  in  12  instruction[31:20]; distinguishes ECALL/EBREAK
- branch_taken  in  1  ALU compare result, valid in EXEC
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req
- dmem_ready  in  1  data access complete this cycle
- ir_wr_en  out  1  load IR with fetched word
- pc_wr_en  out  1  update PC this cycle
- pc_src  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result & ~1 (JALR)
- regfile_wr_en  out  1  register file write strobe
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4
- alu_op  out  2  0 = add, 1 = funct-decoded (R/I), 2 = branch compare
- alu_src_b_imm  out  1  1 = immediate operand
- trap  out  1  sticky; illegal instruction or ECALL/EBREAK seen
- instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset: clk and rst_n as decided (one clock; asynchronous active-low reset). On rst_n low, immediately:
  - state = FETCH; instret = 0; trap = 0.
  - All outputs 0, including imem_req/dmem_req. This holds even mid-transaction.
  - Outstanding memory responses are ignored; memories must tolerate request withdrawal.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Encoding held in the shared package.
- FETCH:
  - imem_req = 1.
  - When imem_ready: ir_wr_en = 1 (same-cycle, Mealy), next state DECODE.
  - Otherwise stay in FETCH with imem_req held.
- DECODE: one cycle; classify opcode.
  - Illegal opcode → TRAP.
  - SYSTEM with funct12 = 0 or 1 → TRAP.
  - FENCE, other SYSTEM → pc_wr_en = 1, pc_src = 0, next FETCH (retires).
  - All others → EXEC.
- EXEC: one cycle. alu_src_b_imm = 1 for I-type, LOAD, STORE, LUI, AUIPC, JALR.
  - R/I-ALU: alu_op = 1 → WB.
  - LUI/AUIPC: alu_op = 0 → WB.
  - LOAD/STORE: alu_op = 0 (address) → MEM.
  - BRANCH: alu_op = 2; pc_wr_en = 1; pc_src = branch_taken ? 1 : 0 → FETCH.
  - JAL/JALR: alu_op = 0 → WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for STORE, 0 for LOAD. Hold until dmem_ready.
  - On dmem_ready: LOAD → WB; STORE → pc_wr_en = 1, pc_src = 0, next FETCH.
- WB: one cycle.
  - regfile_wr_en = 1, pc_wr_en = 1.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_src: 1 for JAL, 2 for JALR, else 0.
  - Writes to x0 are suppressed by the register file, not here.
  - Next FETCH.
- TRAP:
  - Absorbing; trap = 1; all strobes and requests 0.
  - Exit only via reset.
- Minimum latency per instruction, with zero-wait memories (imem_ready high in the first FETCH cycle):
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5; STORE: 4; BRANCH: 3; FENCE: 2.
- Invariants:
  - pc_wr_en pulses exactly once per retired instruction.
  - instret increments on every pc_wr_en and wraps at 2^INSTRET_W.
  - regfile_wr_en is high only in WB.
  - imem_req and dmem_req are never high together.
  - ready inputs are ignored outside their request states.

Decomposition:
- Shared package rv32i_pkg:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM, SYSTEM).
  - state enum.
  - pc_src, wb_sel and alu_op enums.
  - opcode classification function.
- No sub-module; a single FSM plus counter.

Test Plan:
- ADD (0x002081B3), imem_ready and dmem_ready tied 1 → FETCH, DECODE, EXEC, WB; regfile_wr_en high 1 cycle in cycle 4, wb_sel = 0; instret 0→1.
- LW (0x0000A103), dmem_ready delayed 3 cycles → dmem_req high 4 cycles with dmem_we = 0; then WB with wb_sel = 1; total 8 cycles.
- BEQ: branch_taken = 1 → pc_wr_en, pc_src = 1 in cycle 3. branch_taken = 0 → pc_src = 0. regfile_wr_en never high.
- JALR (0x000080E7) → WB with wb_sel = 2, pc_src = 2. SW (0x0020A023) → retires in MEM, regfile_wr_en never high.
- Opcode 0x7F, and ECALL (0x00000073) → TRAP after DECODE; trap = 1; imem_req stays 0 for 20 cycles; instret unchanged.
- Assert rst_n low in MEM with dmem_req = 1 → dmem_req drops the same cycle, before the next clk edge; instret = 0; after release, imem_req = 1 in the first cycle.
